// File: rtl/triangle_raster_sequencer.sv
// Latches one triangle, derives its screen-clamped bounding box and scans it row-major, one pixel per cycle.
// Optional build macro TRIANGLE_RASTER_SKIP_EMPTY_EN drops zero-colour pixels instead of emitting them.
`ifndef FIXEDPOINT_WIDTH
`define FIXEDPOINT_WIDTH 32
`endif

module triangle_raster_sequencer #(
  parameter int FRAC_BITS = 16,
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         tri_valid_i,
  output logic                         tri_ready_o,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v1x_i,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v1y_i,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v2x_i,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v2y_i,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v3x_i,
  input  logic [`FIXEDPOINT_WIDTH-1:0] v3y_i,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v1x_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v1y_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v2x_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v2y_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v3x_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_v3y_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_x_o,
  output logic [`FIXEDPOINT_WIDTH-1:0] ras_y_o,
  input  logic [7:0]                   ras_r_i,
  input  logic [7:0]                   ras_g_i,
  input  logic [7:0]                   ras_b_i,
  output logic                         pix_valid_o,
  input  logic                         pix_ready_i,
  output logic [COORD_W-1:0]           pix_x_o,
  output logic [COORD_W-1:0]           pix_y_o,
  output logic [7:0]                   pix_r_o,
  output logic [7:0]                   pix_g_o,
  output logic [7:0]                   pix_b_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int FP_W = `FIXEDPOINT_WIDTH;
  localparam int IW   = FP_W - FRAC_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [IW-1:0] X_LIM = IW'(SCREEN_W - 1);
  localparam logic signed [IW-1:0] Y_LIM = IW'(SCREEN_H - 1);

  logic [2:0]         state_q, state_d;
  logic [FP_W-1:0]    vert_q [6];
  logic [COORD_W-1:0] curX_q, curX_d, curY_q, curY_d;
  logic [COORD_W-1:0] xMin_q, xMax_q, yMin_q, yMax_q;
  logic               pixValid_q, pixValid_d;
  logic [COORD_W-1:0] pixX_q, pixY_q;
  logic [7:0]         pixR_q, pixG_q, pixB_q;

  logic signed [IW-1:0] xLo, xHi, yLo, yHi, xLoC, xHiC, yLoC, yHiC;
  logic boxEmpty, triAccept, scanning, freeSlot, capture, advance;

  function automatic logic signed [IW-1:0] intPart(input logic [FP_W-1:0] v);
    return IW'($signed(v) >>> FRAC_BITS);
  endfunction

  function automatic logic signed [IW-1:0] min3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [IW-1:0] max3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [IW-1:0] clampInt(input logic signed [IW-1:0] v, lim);
    if (v < 0) return '0;
    if (v > lim) return lim;
    return v;
  endfunction

  // Bounding box is worked out at full integer width so off-screen vertices cannot alias onto the screen.
  always_comb begin
    xLo  = min3(intPart(vert_q[0]), intPart(vert_q[2]), intPart(vert_q[4]));
    xHi  = max3(intPart(vert_q[0]), intPart(vert_q[2]), intPart(vert_q[4]));
    yLo  = min3(intPart(vert_q[1]), intPart(vert_q[3]), intPart(vert_q[5]));
    yHi  = max3(intPart(vert_q[1]), intPart(vert_q[3]), intPart(vert_q[5]));
    xLoC = clampInt(xLo, X_LIM);
    xHiC = clampInt(xHi, X_LIM);
    yLoC = clampInt(yLo, Y_LIM);
    yHiC = clampInt(yHi, Y_LIM);
    boxEmpty = (xHi < 0) || (xLo > X_LIM) || (yHi < 0) || (yLo > Y_LIM) ||
               (xLoC > xHiC) || (yLoC > yHiC);
  end

  assign triAccept = (state_q == S_IDLE) && tri_valid_i;
  assign scanning  = (state_q == S_SCAN);
  assign freeSlot  = !pixValid_q || pix_ready_i;

`ifdef TRIANGLE_RASTER_SKIP_EMPTY_EN
  logic zeroColour;
  assign zeroColour = ((ras_r_i | ras_g_i | ras_b_i) == 8'd0);
  assign capture    = scanning && freeSlot && !zeroColour;
  assign advance    = scanning && (freeSlot || zeroColour);
`else
  assign capture = scanning && freeSlot;
  assign advance = capture;
`endif

  always_comb begin
    state_d    = state_q;
    curX_d     = curX_q;
    curY_d     = curY_q;
    pixValid_d = pixValid_q;
    if (capture) pixValid_d = 1'b1;
    else if (pix_ready_i) pixValid_d = 1'b0;
    case (state_q)
      S_IDLE:  if (tri_valid_i) state_d = S_SETUP;
      S_SETUP: begin
        if (boxEmpty) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SCAN;
          curX_d  = COORD_W'(xLoC);
          curY_d  = COORD_W'(yLoC);
        end
      end
      S_SCAN: begin
        if (advance) begin
          if (curX_q == xMax_q) begin
            curX_d = xMin_q;
            if (curY_q == yMax_q) state_d = S_DRAIN;
            else curY_d = curY_q + 1'b1;
          end else begin
            curX_d = curX_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (!pixValid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      curX_q     <= '0;
      curY_q     <= '0;
      pixValid_q <= 1'b0;
      xMin_q     <= '0;
      xMax_q     <= '0;
      yMin_q     <= '0;
      yMax_q     <= '0;
      pixX_q     <= '0;
      pixY_q     <= '0;
      pixR_q     <= '0;
      pixG_q     <= '0;
      pixB_q     <= '0;
      for (int i = 0; i < 6; i++) vert_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      curX_q     <= curX_d;
      curY_q     <= curY_d;
      pixValid_q <= pixValid_d;
      if (triAccept) begin
        vert_q[0] <= v1x_i;
        vert_q[1] <= v1y_i;
        vert_q[2] <= v2x_i;
        vert_q[3] <= v2y_i;
        vert_q[4] <= v3x_i;
        vert_q[5] <= v3y_i;
      end
      if (state_q == S_SETUP) begin
        xMin_q <= COORD_W'(xLoC);
        xMax_q <= COORD_W'(xHiC);
        yMin_q <= COORD_W'(yLoC);
        yMax_q <= COORD_W'(yHiC);
      end
      if (capture) begin
        pixX_q <= curX_q;
        pixY_q <= curY_q;
        pixR_q <= ras_r_i;
        pixG_q <= ras_g_i;
        pixB_q <= ras_b_i;
      end
    end
  end

  assign tri_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign ras_v1x_o   = vert_q[0];
  assign ras_v1y_o   = vert_q[1];
  assign ras_v2x_o   = vert_q[2];
  assign ras_v2y_o   = vert_q[3];
  assign ras_v3x_o   = vert_q[4];
  assign ras_v3y_o   = vert_q[5];
  assign ras_x_o     = FP_W'(curX_q) << FRAC_BITS;
  assign ras_y_o     = FP_W'(curY_q) << FRAC_BITS;
  assign pix_valid_o = pixValid_q;
  assign pix_x_o     = pixX_q;
  assign pix_y_o     = pixY_q;
  assign pix_r_o     = pixR_q;
  assign pix_g_o     = pixG_q;
  assign pix_b_o     = pixB_q;

endmodule

// File: tb/tb_triangle_raster_sequencer.sv
// Bench for triangle_raster_sequencer: an edge-function rasterizer stub feeds colours back, and a
// bounding-box reference model predicts the pixel stream and handshake timing.
`ifndef FIXEDPOINT_WIDTH
`define FIXEDPOINT_WIDTH 32
`endif

module tb_triangle_raster_sequencer;
  localparam int FW = `FIXEDPOINT_WIDTH;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic clk = 1'b0;
  logic reset_n, tri_valid, tri_ready, pix_valid, pix_ready, busy, done;
  logic [FW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic [FW-1:0] rv1x, rv1y, rv2x, rv2y, rv3x, rv3y, ras_x, ras_y;
  logic [7:0] ras_r, ras_g, ras_b, pix_r, pix_g, pix_b;
  logic [9:0] pix_x, pix_y;

  int passCount = 0;
  int checkCount = 0;
  int triV[6];
  bit colourMode;
  pix_t gotPix[$];
  pix_t expPix[$];
  int hsCycle, firstValid, doneCycle, doneCnt, stallErr, lastAccept;
  bit timedOut, readyAfter, aborted;

  always #5 clk = ~clk;

  triangle_raster_sequencer dut (
    .clk_i(clk), .reset_n_i(reset_n), .tri_valid_i(tri_valid), .tri_ready_o(tri_ready),
    .v1x_i(v1x), .v1y_i(v1y), .v2x_i(v2x), .v2y_i(v2y), .v3x_i(v3x), .v3y_i(v3y),
    .ras_v1x_o(rv1x), .ras_v1y_o(rv1y), .ras_v2x_o(rv2x), .ras_v2y_o(rv2y),
    .ras_v3x_o(rv3x), .ras_v3y_o(rv3y), .ras_x_o(ras_x), .ras_y_o(ras_y),
    .ras_r_i(ras_r), .ras_g_i(ras_g), .ras_b_i(ras_b),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_x_o(pix_x), .pix_y_o(pix_y),
    .pix_r_o(pix_r), .pix_g_o(pix_g), .pix_b_o(pix_b), .busy_o(busy), .done_o(done)
  );

  // Coverage test by edge functions on integer vertices; edges count as inside.
  function automatic logic [23:0] colourAt(input int px, py, ax, ay, bx, by, cx, cy, input bit mode);
    longint e0, e1, e2;
    e0 = longint'(bx - ax) * (py - ay) - longint'(by - ay) * (px - ax);
    e1 = longint'(cx - bx) * (py - by) - longint'(cy - by) * (px - bx);
    e2 = longint'(ax - cx) * (py - cy) - longint'(ay - cy) * (px - cx);
    if (!((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))) return 24'h0;
    if (!mode) return 24'hFFFFFF;
    return {8'(px * 5 + 1), 8'(py * 3 + 2), 8'(px ^ py) | 8'h80};
  endfunction

  assign {ras_r, ras_g, ras_b} = colourAt(
    int'($signed(ras_x) >>> 16), int'($signed(ras_y) >>> 16),
    int'($signed(rv1x) >>> 16), int'($signed(rv1y) >>> 16),
    int'($signed(rv2x) >>> 16), int'($signed(rv2y) >>> 16),
    int'($signed(rv3x) >>> 16), int'($signed(rv3y) >>> 16), colourMode);

  // Expected pixel stream straight from the box/clamp/scan rules.
  function automatic void buildExpected();
    int ix[3], iy[3];
    int xlo, xhi, ylo, yhi;
    logic [23:0] c;
    expPix.delete();
    for (int k = 0; k < 3; k++) begin
      ix[k] = triV[2*k] >>> 16;
      iy[k] = triV[2*k+1] >>> 16;
    end
    xlo = ix[0]; xhi = ix[0]; ylo = iy[0]; yhi = iy[0];
    for (int k = 1; k < 3; k++) begin
      if (ix[k] < xlo) xlo = ix[k];
      if (ix[k] > xhi) xhi = ix[k];
      if (iy[k] < ylo) ylo = iy[k];
      if (iy[k] > yhi) yhi = iy[k];
    end
    if (xhi < 0 || xlo > 639 || yhi < 0 || ylo > 479) return;
    if (xlo < 0) xlo = 0;
    if (ylo < 0) ylo = 0;
    if (xhi > 639) xhi = 639;
    if (yhi > 479) yhi = 479;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        c = colourAt(x, y, ix[0], iy[0], ix[1], iy[1], ix[2], iy[2], colourMode);
`ifdef TRIANGLE_RASTER_SKIP_EMPTY_EN
        if (c == 24'h0) continue;
`endif
        expPix.push_back({10'(x), 10'(y), c});
      end
    end
  endfunction

  function automatic void setTri(input int ax, ay, bx, by, cx, cy);
    triV[0] = ax * 65536; triV[1] = ay * 65536;
    triV[2] = bx * 65536; triV[3] = by * 65536;
    triV[4] = cx * 65536; triV[5] = cy * 65536;
  endfunction

  // Drives one request and records handshake, pixel acceptances, done timing and stall stability.
  task automatic runTriangle(input int readyPct, input bit holdValid, input int abortAt);
    int cyc;
    bit prevStall;
    pix_t nowPix, prevPix;
    logic [FW-1:0] prevRx, prevRy;
    gotPix.delete();
    hsCycle = -1; firstValid = -1; doneCycle = -1; doneCnt = 0; stallErr = 0; lastAccept = -1;
    timedOut = 0; aborted = 0; readyAfter = 0; prevStall = 0;
    prevPix = '0; prevRx = '0; prevRy = '0;
    @(posedge clk); #1;
    v1x = triV[0]; v1y = triV[1]; v2x = triV[2]; v2y = triV[3]; v3x = triV[4]; v3y = triV[5];
    tri_valid = 1'b1;
    pix_ready = (int'($urandom_range(99)) < readyPct);
    cyc = 0;
    forever begin
      @(negedge clk);
      nowPix = {pix_x, pix_y, pix_r, pix_g, pix_b};
      if (hsCycle < 0 && tri_valid && tri_ready) hsCycle = cyc;
      if (doneCycle >= 0 && cyc == doneCycle + 1) begin
        readyAfter = tri_ready;
        break;
      end
      if (firstValid < 0 && pix_valid) firstValid = cyc;
      if (prevStall && (!pix_valid || nowPix !== prevPix)) stallErr++;
`ifndef TRIANGLE_RASTER_SKIP_EMPTY_EN
      if (prevStall && (ras_x !== prevRx || ras_y !== prevRy)) stallErr++;
`endif
      prevStall = pix_valid && !pix_ready;
      prevPix = nowPix; prevRx = ras_x; prevRy = ras_y;
      if (pix_valid && pix_ready) begin
        gotPix.push_back(nowPix);
        lastAccept = cyc;
      end
      if (done) begin
        doneCnt++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (abortAt > 0 && gotPix.size() == abortAt) begin
        aborted = 1;
        break;
      end
      if (cyc >= 6000) begin
        timedOut = 1;
        break;
      end
      @(posedge clk); #1;
      if (hsCycle >= 0) begin
        tri_valid = holdValid && (doneCycle < 0);
        v1x = $urandom; v1y = $urandom; v2x = $urandom; v2y = $urandom; v3x = $urandom; v3y = $urandom;
      end
      pix_ready = (int'($urandom_range(99)) < readyPct);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (tri_ready !== 1'b1) $display("[TB] FAIL reset_tri_ready: got %b, expected 1", tri_ready); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passCount++;
    checkCount++;
    if (pix_valid !== 1'b0) $display("[TB] FAIL reset_pix_valid: got %b, expected 0", pix_valid); else passCount++;
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done); else passCount++;
    checkCount++;
    if (ras_x !== '0 || ras_y !== '0) $display("[TB] FAIL reset_ras_xy: got %h/%h, expected 0/0", ras_x, ras_y); else passCount++;
    checkCount++;
    if (pix_x !== '0 || pix_y !== '0) $display("[TB] FAIL reset_pix_xy: got %0d/%0d, expected 0/0", pix_x, pix_y); else passCount++;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_plan_triangle();
    colourMode = 0;
    setTri(0, 0, 3, 0, 0, 3);
    buildExpected();
    runTriangle(100, 0, 0);
    checkCount++;
    if (timedOut) $display("[TB] FAIL plan_timeout: got no done, expected done"); else passCount++;
    checkCount++;
    if (gotPix.size() !== expPix.size()) $display("[TB] FAIL plan_count: got %0d, expected %0d", gotPix.size(), expPix.size()); else passCount++;
    for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
      checkCount++;
      if (gotPix[i] !== expPix[i])
        $display("[TB] FAIL plan_pixel[%0d]: got (%0d,%0d) rgb %h, expected (%0d,%0d) rgb %h", i,
                 gotPix[i].x, gotPix[i].y, {gotPix[i].r, gotPix[i].g, gotPix[i].b},
                 expPix[i].x, expPix[i].y, {expPix[i].r, expPix[i].g, expPix[i].b});
      else passCount++;
    end
    checkCount++;
    if (doneCnt !== 1) $display("[TB] FAIL plan_done_pulses: got %0d, expected 1", doneCnt); else passCount++;
`ifndef TRIANGLE_RASTER_SKIP_EMPTY_EN
    checkCount++;
    if (firstValid - hsCycle !== 3) $display("[TB] FAIL plan_first_valid: got T+%0d, expected T+3", firstValid - hsCycle); else passCount++;
    checkCount++;
    if (doneCycle - hsCycle !== 20) $display("[TB] FAIL plan_done_time: got T+%0d, expected T+20", doneCycle - hsCycle); else passCount++;
`endif
    checkCount++;
    if (readyAfter !== 1'b1) $display("[TB] FAIL plan_ready_after: got %b, expected 1", readyAfter); else passCount++;
  endtask

  task automatic test_offscreen();
    colourMode = 0;
    setTri(-10, 2, -3, 5, -7, 9);
    runTriangle(100, 0, 0);
    checkCount++;
    if (gotPix.size() !== 0 || firstValid !== -1) $display("[TB] FAIL offscreen_pixels: got %0d pixels, expected 0", gotPix.size()); else passCount++;
    checkCount++;
    if (doneCycle - hsCycle !== 2) $display("[TB] FAIL offscreen_done_time: got T+%0d, expected T+2", doneCycle - hsCycle); else passCount++;
    checkCount++;
    if (readyAfter !== 1'b1) $display("[TB] FAIL offscreen_ready_t3: got %b, expected 1", readyAfter); else passCount++;
  endtask

  task automatic test_straddle();
    colourMode = 0;
    setTri(-5, -5, 2, -5, -5, 2);
    buildExpected();
    runTriangle(100, 0, 0);
    checkCount++;
    if (gotPix.size() !== expPix.size()) $display("[TB] FAIL straddle_count: got %0d, expected %0d", gotPix.size(), expPix.size()); else passCount++;
    for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
      checkCount++;
      if (gotPix[i] !== expPix[i])
        $display("[TB] FAIL straddle_pixel[%0d]: got (%0d,%0d) rgb %h, expected (%0d,%0d) rgb %h", i,
                 gotPix[i].x, gotPix[i].y, {gotPix[i].r, gotPix[i].g, gotPix[i].b},
                 expPix[i].x, expPix[i].y, {expPix[i].r, expPix[i].g, expPix[i].b});
      else passCount++;
    end
    checkCount++;
    if (doneCnt !== 1 || timedOut) $display("[TB] FAIL straddle_done: got %0d pulses, expected 1", doneCnt); else passCount++;
  endtask

  task automatic test_backpressure();
    colourMode = 1;
    setTri(0, 0, 3, 0, 0, 3);
    buildExpected();
    runTriangle(50, 0, 0);
    checkCount++;
    if (gotPix.size() !== expPix.size()) $display("[TB] FAIL bp_count: got %0d, expected %0d", gotPix.size(), expPix.size()); else passCount++;
    for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
      checkCount++;
      if (gotPix[i] !== expPix[i])
        $display("[TB] FAIL bp_pixel[%0d]: got (%0d,%0d), expected (%0d,%0d)", i,
                 gotPix[i].x, gotPix[i].y, expPix[i].x, expPix[i].y);
      else passCount++;
    end
    checkCount++;
    if (stallErr !== 0) $display("[TB] FAIL bp_stall_stable: got %0d changes, expected 0", stallErr); else passCount++;
    checkCount++;
    if (doneCycle <= lastAccept || timedOut) $display("[TB] FAIL bp_done_order: got done %0d last accept %0d, expected done later", doneCycle, lastAccept); else passCount++;
  endtask

  task automatic test_back_to_back();
    colourMode = 1;
    setTri(0, 0, 3, 0, 0, 3);
    buildExpected();
    runTriangle(100, 1, 0);
    checkCount++;
    if (gotPix.size() !== expPix.size() || doneCnt !== 1)
      $display("[TB] FAIL b2b_first: got %0d pixels %0d dones, expected %0d pixels 1 done", gotPix.size(), doneCnt, expPix.size());
    else passCount++;
    setTri(4, 6, 6, 6, 5, 7);
    buildExpected();
    runTriangle(100, 0, 0);
    checkCount++;
    if (gotPix.size() !== expPix.size()) $display("[TB] FAIL b2b_second_count: got %0d, expected %0d", gotPix.size(), expPix.size()); else passCount++;
    for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
      checkCount++;
      if (gotPix[i] !== expPix[i])
        $display("[TB] FAIL b2b_pixel[%0d]: got (%0d,%0d) rgb %h, expected (%0d,%0d) rgb %h", i,
                 gotPix[i].x, gotPix[i].y, {gotPix[i].r, gotPix[i].g, gotPix[i].b},
                 expPix[i].x, expPix[i].y, {expPix[i].r, expPix[i].g, expPix[i].b});
      else passCount++;
    end
  endtask

  task automatic test_reset_mid_scan();
    colourMode = 1;
    setTri(0, 0, 7, 0, 0, 7);
    runTriangle(100, 0, 5);
    checkCount++;
    if (!aborted) $display("[TB] FAIL midreset_reach: got %0d pixels, expected 5 before reset", gotPix.size()); else passCount++;
    @(posedge clk); #1;
    reset_n = 1'b0;
    tri_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (pix_valid !== 1'b0) $display("[TB] FAIL midreset_pix_valid: got %b, expected 0", pix_valid); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); else passCount++;
    checkCount++;
    if (tri_ready !== 1'b1) $display("[TB] FAIL midreset_tri_ready: got %b, expected 1", tri_ready); else passCount++;
    checkCount++;
    if (rv1x !== '0 || ras_x !== '0) $display("[TB] FAIL midreset_ras: got %h/%h, expected 0/0", rv1x, ras_x); else passCount++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    setTri(2, 3, 6, 3, 2, 9);
    buildExpected();
    runTriangle(100, 0, 0);
    checkCount++;
    if (gotPix.size() !== expPix.size()) $display("[TB] FAIL midreset_new_count: got %0d, expected %0d", gotPix.size(), expPix.size()); else passCount++;
    for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
      checkCount++;
      if (gotPix[i] !== expPix[i])
        $display("[TB] FAIL midreset_pixel[%0d]: got (%0d,%0d), expected (%0d,%0d)", i,
                 gotPix[i].x, gotPix[i].y, expPix[i].x, expPix[i].y);
      else passCount++;
    end
  endtask

  task automatic test_random_triangles();
    for (int n = 0; n < 8; n++) begin
      colourMode = 1'($urandom_range(1));
      for (int k = 0; k < 6; k++)
        triV[k] = (int'($urandom_range(18)) - 6) * 65536 + int'($urandom_range(65535));
      buildExpected();
      runTriangle(30 + int'($urandom_range(70)), 1'($urandom_range(1)), 0);
      checkCount++;
      if (timedOut || doneCnt !== 1) $display("[TB] FAIL rand%0d_done: got %0d pulses timeout %b, expected 1", n, doneCnt, timedOut); else passCount++;
      checkCount++;
      if (gotPix.size() !== expPix.size()) $display("[TB] FAIL rand%0d_count: got %0d, expected %0d", n, gotPix.size(), expPix.size()); else passCount++;
      for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
        checkCount++;
        if (gotPix[i] !== expPix[i])
          $display("[TB] FAIL rand%0d_pixel[%0d]: got (%0d,%0d) rgb %h, expected (%0d,%0d) rgb %h", n, i,
                   gotPix[i].x, gotPix[i].y, {gotPix[i].r, gotPix[i].g, gotPix[i].b},
                   expPix[i].x, expPix[i].y, {expPix[i].r, expPix[i].g, expPix[i].b});
        else passCount++;
      end
      checkCount++;
      if (stallErr !== 0) $display("[TB] FAIL rand%0d_stall_stable: got %0d changes, expected 0", n, stallErr); else passCount++;
    end
  endtask

  initial begin
    reset_n = 1'b0; tri_valid = 1'b0; pix_ready = 1'b0; colourMode = 1'b0;
    v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
    test_reset();
    test_plan_triangle();
    test_offscreen();
    test_straddle();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_random_triangles();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/triangle_raster_sequencer.md
# triangle_raster_sequencer

Sequences the combinational triangle rasterizer over a triangle's screen-space bounding box. Accepts one triangle per request, latches its fixed-point vertices, computes a screen-clamped integer bounding box, then scans it row-major one pixel per cycle. It drives the rasterizer's `x`/`y`/vertex inputs and emits coloured pixels to the framebuffer writer over a valid/ready stream. It sits between the triangle setup stage and the framebuffer write port.

## Interface
- `FRAC_BITS`, 16: fractional bits of the `` `FIXEDPOINT_WIDTH `` fixed-point format (from FixedPoint.vh).
- `COORD_W`, 10: width of integer pixel coordinates.
- `SCREEN_W`, 640: screen width in pixels.
- `SCREEN_H`, 480: screen height in pixels.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `tri_valid`  in  1  triangle request.
- `tri_ready`  out  1  high only in IDLE.
- `v1x, v1y, v2x, v2y, v3x, v3y`  in  `` `FIXEDPOINT_WIDTH `` each  signed fixed-point vertices; sampled on the handshake.
- `ras_v1x … ras_v3y`  out  `` `FIXEDPOINT_WIDTH `` each  latched vertices to the rasterizer.
- `ras_x, ras_y`  out  `` `FIXEDPOINT_WIDTH ``  current pixel as fixed point, `cur << FRAC_BITS`.
- `ras_r, ras_g, ras_b`  in  8 each  rasterizer colour for `ras_x`/`ras_y`; combinational, same cycle.
- `pix_valid`  out  1  output pixel valid.
- `pix_ready`  in  1  downstream accepts.
- `pix_x, pix_y`  out  `COORD_W` each  integer pixel coordinate.
- `pix_r, pix_g, pix_b`  out  8 each  pixel colour.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the triangle is complete.

## Operation
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- **IDLE:**
  - `tri_ready=1`.
  - On `tri_valid && tri_ready`: latch vertices into `ras_v*` and go to SETUP.
- **SETUP (1 cycle):**
  - Integer part of each vertex coordinate: `v >>> FRAC_BITS`, arithmetic shift, i.e. floor.
  - `xmin/xmax` = min/max of the three x integers; `ymin/ymax` likewise.
  - Clamp to [0, SCREEN_W-1] and [0, SCREEN_H-1].
  - Box empty when an unclamped max < 0, an unclamped min > screen limit, or clamped min > max. Empty box: go to DONE, emit no pixels.
  - Otherwise load `cur_x=xmin`, `cur_y=ymin` and go to SCAN.
- **SCAN:**
  - `ras_x`/`ras_y` are driven from `cur_x`/`cur_y`.
  - The one-entry output register is free when `!pix_valid || pix_ready`.
  - When free, capture `{cur_x, cur_y, ras_r, ras_g, ras_b}`, set `pix_valid`, and advance.
  - Advance rule: `cur_x++`. At `xmax`: `cur_x=xmin`, `cur_y++`. At `(xmax, ymax)`: go to DRAIN.
  - When not free, hold `cur_*`; `ras_x`/`ras_y` stay stable.
- **DRAIN:** wait until `pix_valid` clears (last pixel accepted), then go to DONE.
- **DONE (1 cycle):** `done=1`, then IDLE.
- Output register: `pix_valid` clears on `pix_ready` when no new capture happens in the same cycle. Output fields hold stable while `pix_valid && !pix_ready`.
- Arithmetic:
  - Min/max and clamp are done at `` `FIXEDPOINT_WIDTH-FRAC_BITS `` signed width before truncating to `COORD_W`.
  - Counter comparisons use equality against `xmax`/`ymax`, so there is no wrap.
- Reset: on `clk` edge with `reset_n=0`, regardless of state:
  - state ← IDLE.
  - `pix_valid`, `done`, `busy` ← 0.
  - `ras_*`, `pix_*`, `cur_*`, bbox ← 0.
  - Any in-flight triangle is discarded.

## Timing
- Handshake at cycle T; SETUP at T+1; first SCAN cycle at T+2; first `pix_valid` at T+3.
- Throughput is 1 pixel/cycle while `pix_ready=1`.
- With N pixels in the box and no stalls: last pixel valid at T+2+N, DRAIN at T+3+N, `done` at T+4+N, `tri_ready` high again at T+5+N.
- Empty box: `done` at T+2, no `pix_valid`.
- Stall: any cycle with `pix_valid && !pix_ready` adds one cycle; no pixel is dropped or duplicated.
- `tri_valid` is ignored outside IDLE.
- `tri_ready` is a combinational decode of state; reset value 1 after the first reset edge.

## Configuration
- `TRIANGLE_RASTER_SKIP_EMPTY_EN`:
  - **Defined:** a scanned pixel with `ras_r|ras_g|ras_b == 0` is not captured. The scan advances that cycle without needing a free output register, so black/uncovered pixels cost one cycle and produce no transfer.
  - **Undefined:** every bounding-box pixel is emitted, including zero colour.

## Test plan
- **Triangle (0,0),(3,0),(0,3) integer-valued fixed point, `pix_ready=1`, macro undefined:**
  - Exactly 16 pixels, order (0,0),(1,0)…(3,3).
  - Covered pixels (x+y≤3) = 255/255/255, others 0.
  - `done` at T+20.
- **Same triangle, macro defined:** exactly 10 pixels, all 255, same row-major order; `done` pulses once.
- **Vertices fully off-screen (all x < 0):** no `pix_valid`; `done` at T+2; `tri_ready` at T+3.
- **Triangle straddling the screen edge, (−5,−5),(2,−5),(−5,2):**
  - Box clamped to (0,0)…(2,2): 9 pixels, none with negative coordinates.
  - Pixels with x+y≤−3+… match the reference model.
- **Random `pix_ready` backpressure (50%) on a 4×4 box:**
  - All 16 pixels delivered once, in order.
  - Outputs stable during stalls; `done` only after the last acceptance.
- **Reset asserted mid-SCAN at pixel 5:**
  - Next edge: `pix_valid=0`, `busy=0`, `tri_ready=1`.
  - A new triangle then runs from its own `(xmin, ymin)`.
